timer_capture_arbiter: RTL and testbench

Multi-channel input-capture controller for the APB timer. It runs one edge detector per capture pin and snapshots the timer count into a per-channel holding register on each enabled edge. It then drains pending captures, one per cycle at most, through a round-robin arbiter to a single valid/ready capture port. The port feeds the timer's capture register file and its interrupt logic.

---
 rtl/timer_pkg.sv | 26 ++
 rtl/edge_detector_timer.sv | 43 ++++
 rtl/timer_capture_arbiter.sv | 123 ++++++++++++
 tb/tb_timer_capture_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared types for the timer input-capture block: capture record, edge-mode
// encoding and the output register state.
package timer_pkg;

  // Record fields are sized for the largest supported configuration
  // (16 channels, 64-bit count); instances use the low bits.
  localparam int REC_CH_W  = 4;
  localparam int REC_VAL_W = 64;

  typedef struct packed {
    logic [REC_CH_W-1:0]  ch;
    logic [REC_VAL_W-1:0] value;
  } cap_rec_t;

  // Edge mode is {EDGEnB, EDGEnA}
  localparam logic [1:0] EDGE_OFF  = 2'b00;
  localparam logic [1:0] EDGE_RISE = 2'b01;
  localparam logic [1:0] EDGE_FALL = 2'b10;
  localparam logic [1:0] EDGE_BOTH = 2'b11;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } cap_state_e;

endpackage

// File: rtl/edge_detector_timer.sv
// Per-bit edge detector with independent rise/fall enables. The sample
// register resets to 0, so a pin already high out of reset reads as a rise.
module edge_detector_timer
  import timer_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [WIDTH-1:0] sig,
  input  logic [WIDTH-1:0] rise_en,
  input  logic [WIDTH-1:0] fall_en,
  output logic [WIDTH-1:0] edge_out
);

  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] rise_v;
  logic [WIDTH-1:0] fall_v;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      prev_q <= '0;
    end else begin
      prev_q <= sig;
    end
  end

  assign rise_v = sig & ~prev_q;
  assign fall_v = ~sig & prev_q;

  always_comb begin
    edge_out = '0;
    for (int i = 0; i < WIDTH; i++) begin
      case ({fall_en[i], rise_en[i]})
        EDGE_RISE: edge_out[i] = rise_v[i];
        EDGE_FALL: edge_out[i] = fall_v[i];
        EDGE_BOTH: edge_out[i] = rise_v[i] | fall_v[i];
        default:   edge_out[i] = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/timer_capture_arbiter.sv
// Multi-channel input capture: snapshots count on enabled pin edges into
// per-channel holding registers and drains them round-robin to one port.
module timer_capture_arbiter
  import timer_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic                      en,
  input  logic [NUM_CH-1:0]         cap_in,
  input  logic [NUM_CH-1:0]         edge_a,
  input  logic [NUM_CH-1:0]         edge_b,
  input  logic [CNT_W-1:0]          count,
  input  logic [NUM_CH-1:0]         ovr_clr,
  output logic                      cap_valid,
  input  logic                      cap_ready,
  output logic [$clog2(NUM_CH)-1:0] cap_ch,
  output logic [CNT_W-1:0]          cap_value,
  output logic [NUM_CH-1:0]         pending,
  output logic [NUM_CH-1:0]         overrun
);

  localparam int CH_W = $clog2(NUM_CH);

  // Handshake: a record transfers on a cycle where cap_valid and cap_ready
  // are both high; while cap_valid is high the record is held unchanged.

  logic [NUM_CH-1:0] edge_raw;
  logic [NUM_CH-1:0] cap_edge;
  logic [NUM_CH-1:0] pending_q;
  logic [NUM_CH-1:0] overrun_q;
  logic [CNT_W-1:0]  hold_q [NUM_CH];
  logic [CH_W-1:0]   rr_ptr_q;
  cap_state_e        state_q;
  cap_rec_t          out_q;

  logic              grant_found;
  logic [CH_W-1:0]   grant_idx;
  logic [CH_W-1:0]   cand;
  int                arb_idx;
  logic              load;
  logic [NUM_CH-1:0] grant_vec;
  logic              unused_rec;

  edge_detector_timer #(.WIDTH(NUM_CH)) u_edge (
    .clk      (clk),
    .n_rst    (n_rst),
    .sig      (cap_in),
    .rise_en  (edge_a),
    .fall_en  (edge_b),
    .edge_out (edge_raw)
  );

  assign cap_edge = edge_raw & {NUM_CH{en}};

  // First pending channel at or after rr_ptr, wrapping
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    arb_idx     = 0;
    cand        = '0;
    for (int off = 0; off < NUM_CH; off++) begin
      arb_idx = int'(rr_ptr_q) + off;
      if (arb_idx >= NUM_CH) arb_idx = arb_idx - NUM_CH;
      cand = CH_W'(arb_idx);
      if (!grant_found && pending_q[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign load      = ((state_q == ST_EMPTY) || cap_ready) && grant_found;
  assign grant_vec = load ? (NUM_CH'(1) << grant_idx) : '0;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pending_q <= '0;
      overrun_q <= '0;
      for (int i = 0; i < NUM_CH; i++) hold_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        // A channel being granted this cycle frees its slot for a new edge
        if (cap_edge[i] && (!pending_q[i] || grant_vec[i])) begin
          hold_q[i]    <= count;
          pending_q[i] <= 1'b1;
        end else if (grant_vec[i]) begin
          pending_q[i] <= 1'b0;
        end
        if (cap_edge[i] && pending_q[i] && !grant_vec[i]) begin
          overrun_q[i] <= 1'b1;
        end else if (ovr_clr[i]) begin
          overrun_q[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= ST_EMPTY;
      out_q    <= '0;
      rr_ptr_q <= '0;
    end else if (load) begin
      out_q.ch    <= REC_CH_W'(grant_idx);
      out_q.value <= REC_VAL_W'(hold_q[grant_idx]);
      state_q     <= ST_FULL;
      rr_ptr_q    <= (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + CH_W'(1);
    end else if ((state_q == ST_FULL) && cap_ready) begin
      state_q <= ST_EMPTY;
    end
  end

  assign cap_valid  = (state_q == ST_FULL);
  assign cap_ch     = out_q.ch[CH_W-1:0];
  assign cap_value  = out_q.value[CNT_W-1:0];
  assign pending    = pending_q;
  assign overrun    = overrun_q;
  assign unused_rec = ^out_q;

endmodule

// File: tb/tb_timer_capture_arbiter.sv
// Bench for timer_capture_arbiter: directed test-plan scenarios plus random
// traffic against a rule-level reference model with an expected-record queue.
module tb_timer_capture_arbiter;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 32;
  localparam int CH_W   = 2;
  localparam int W      = CH_W + CNT_W;

  logic              clk;
  logic              n_rst;
  logic              en;
  logic [NUM_CH-1:0] cap_in;
  logic [NUM_CH-1:0] edge_a;
  logic [NUM_CH-1:0] edge_b;
  logic [CNT_W-1:0]  count;
  logic [NUM_CH-1:0] ovr_clr;
  logic              cap_valid;
  logic              cap_ready;
  logic [CH_W-1:0]   cap_ch;
  logic [CNT_W-1:0]  cap_value;
  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] overrun;

  timer_capture_arbiter #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .en        (en),
    .cap_in    (cap_in),
    .edge_a    (edge_a),
    .edge_b    (edge_b),
    .count     (count),
    .ovr_clr   (ovr_clr),
    .cap_valid (cap_valid),
    .cap_ready (cap_ready),
    .cap_ch    (cap_ch),
    .cap_value (cap_value),
    .pending   (pending),
    .overrun   (overrun)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] exp_q[$];

  // Reference model state
  logic [NUM_CH-1:0] m_pending;
  logic [NUM_CH-1:0] m_overrun;
  logic [NUM_CH-1:0] m_prev;
  logic [CNT_W-1:0]  m_hold [NUM_CH];
  int                m_rr;
  logic              m_full;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_pending = '0;
    m_overrun = '0;
    m_prev    = '0;
    m_rr      = 0;
    m_full    = 1'b0;
    for (int i = 0; i < NUM_CH; i++) m_hold[i] = '0;
    exp_q.delete();
  endtask

  // One clock of the capture rules: drain first (so a freed slot can take a
  // same-cycle edge), then capture edges, then overrun set/clear.
  task automatic model_step();
    logic [NUM_CH-1:0] ev;
    bit accept;
    int g;
    int c;
    for (int i = 0; i < NUM_CH; i++)
      ev[i] = en && ((cap_in[i] && !m_prev[i] && edge_a[i]) ||
                     (!cap_in[i] && m_prev[i] && edge_b[i]));
    accept = !m_full || cap_ready;
    g = -1;
    if (accept) begin
      for (int off = 0; off < NUM_CH; off++) begin
        c = (m_rr + off) % NUM_CH;
        if (g < 0 && m_pending[c]) g = c;
      end
    end
    if (g >= 0) begin
      exp_q.push_back({CH_W'(g), m_hold[g]});
      m_pending[g] = 1'b0;
      m_rr = (g + 1) % NUM_CH;
      m_full = 1'b1;
    end else if (accept) begin
      m_full = 1'b0;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (ev[i] && m_pending[i]) begin
        m_overrun[i] = 1'b1;
      end else begin
        if (ev[i]) begin
          m_hold[i]    = count;
          m_pending[i] = 1'b1;
        end
        if (ovr_clr[i]) m_overrun[i] = 1'b0;
      end
    end
    m_prev = cap_in;
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk or negedge n_rst);
      if (!n_rst) model_clear();
      else model_step();
    end
  end

  // Monitor: per-cycle flag checks plus scoreboard pop on each transfer
  initial begin
    logic [W-1:0] rec;
    forever begin
      @(negedge clk);
      check("cap_valid", cap_valid, m_full);
      check("pending", pending, m_pending);
      check("overrun", overrun, m_overrun);
      if (n_rst && cap_valid && cap_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rec_unexpected: got ch=%0d value=%0h expected no record at %0t",
                   cap_ch, cap_value, $time);
        end else begin
          rec = exp_q.pop_front();
          check("rec_ch", cap_ch, rec[W-1:CNT_W]);
          check("rec_value", cap_value, rec[CNT_W-1:0]);
        end
      end
    end
  end

  // Driver
  task automatic tick();
    @(posedge clk);
    #2;
    ovr_clr = '0;
    count   = count + 1;
  endtask

  initial begin
    n_rst     = 1'b0;
    en        = 1'b0;
    cap_in    = '0;
    edge_a    = '0;
    edge_b    = '0;
    count     = '0;
    ovr_clr   = '0;
    cap_ready = 1'b0;
    repeat (3) tick();
    check("rst_valid", cap_valid, 0);
    check("rst_ch", cap_ch, 0);
    check("rst_value", cap_value, 0);
    check("rst_pending", pending, 0);
    check("rst_overrun", overrun, 0);
    n_rst = 1'b1;

    // Rise-only on channel 1
    en = 1'b1; edge_a = 4'b0010; cap_ready = 1'b1;
    repeat (2) tick();
    count = 100; cap_in = 4'b0010;
    tick();
    check("t1_pending_set", pending, 4'b0010);
    check("t1_not_valid_yet", cap_valid, 0);
    tick();
    check("t1_valid", cap_valid, 1);
    check("t1_ch", cap_ch, 1);
    check("t1_value", cap_value, 100);
    check("t1_pending_clr", pending, 0);
    tick();
    check("t1_one_cycle", cap_valid, 0);

    // Fall-only on channel 2: rise ignored, fall captured
    edge_a = '0; edge_b = 4'b0100;
    cap_in = 4'b0110;
    repeat (3) tick();
    check("t2_rise_ignored", pending, 0);
    count = 250; cap_in = 4'b0010;
    repeat (2) tick();
    check("t2_valid", cap_valid, 1);
    check("t2_ch", cap_ch, 2);
    check("t2_value", cap_value, 250);
    tick();

    // Simultaneous edges on 0, 1, 3 held back by cap_ready=0
    edge_b = '0; edge_a = 4'b1011; cap_ready = 1'b0;
    cap_in = '0;
    repeat (2) tick();
    count = 40; cap_in = 4'b1011;
    repeat (6) tick();
    cap_ready = 1'b1;
    repeat (4) tick();
    cap_in = '0; tick();
    cap_in = 4'b1001;
    repeat (4) tick();

    // Overrun on channel 0 while the output is occupied
    edge_a = '0; edge_b = '0; cap_ready = 1'b0; cap_in = '0;
    repeat (2) tick();
    edge_a = 4'b0011; edge_b = 4'b0001;
    count = 5; cap_in = 4'b0010;
    repeat (2) tick();
    count = 10; cap_in = 4'b0011;
    tick();
    count = 20; cap_in = 4'b0010;
    tick();
    check("t4_overrun_set", overrun[0], 1);
    cap_in = 4'b0011; ovr_clr = 4'b0001;
    tick();
    check("t4_set_beats_clr", overrun[0], 1);
    tick();
    ovr_clr = 4'b0001;
    tick();
    check("t4_clr", overrun[0], 0);
    cap_ready = 1'b1;
    tick();
    check("t4_rec_ch", cap_ch, 0);
    check("t4_rec_value", cap_value, 10);
    repeat (3) tick();

    // Mid-operation reset with a record presented and two pending
    cap_ready = 1'b0; edge_a = 4'b0111; edge_b = '0; cap_in = '0;
    repeat (2) tick();
    cap_in = 4'b0111;
    repeat (2) tick();
    check("t5_valid_before", cap_valid, 1);
    check("t5_two_pending", $countones(pending), 2);
    #1;
    n_rst = 1'b0;
    #1;
    check("t5_rst_valid", cap_valid, 0);
    check("t5_rst_pending", pending, 0);
    check("t5_rst_overrun", overrun, 0);
    check("t5_rst_value", cap_value, 0);
    repeat (2) tick();
    n_rst = 1'b1; en = 1'b0; cap_in = '0;
    tick();
    cap_in = 4'b0111;
    repeat (2) tick();
    check("t5_en_off", pending, 0);

    // Random traffic
    en = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      en        = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 15) == 0) begin
        edge_a = NUM_CH'($urandom);
        edge_b = NUM_CH'($urandom);
      end
      cap_in    = NUM_CH'($urandom);
      cap_ready = ($urandom_range(0, 3) != 0);
      ovr_clr   = ($urandom_range(0, 7) == 0) ? NUM_CH'($urandom) : '0;
      count     = $urandom;
      tick();
    end

    // Drain everything left
    en = 1'b0; cap_ready = 1'b1;
    repeat (20) tick();
    check("drain_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
